// File: rtl/trace_capture.sv
// ----------------------------------------------------------------------------
// trace_capture
//   Records one trace entry per accepted instruction retire. Each entry is
//   put into a first-word-fall-through record FIFO for a downstream consumer.
//   It also keeps instruction/cycle counters, a cycle watchdog and sticky
//   halt/timeout/overflow status.
//
// Parameters
//   DW        datapath / PC width
//   DEPTH     record FIFO entries (power of 2, >= 2)
//   CNT_W     instruction / cycle counter width
//   CYC_LIMIT watchdog limit on enabled cycles
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  capture enable; low freezes counters and capture
//   ret_valid, pc       one instruction retires this cycle, and its PC
//   reg_we/idx/data     register file write of the retiring instruction
//   mem_rd/wr/addr/data data memory access of the retiring instruction
//   hlt                 retiring instruction is a halt
//   out_valid/ready     FIFO head handshake (pop on valid & ready)
//   out_kind .. value   head record fields, all zero while FIFO empty
//   inst_count          accepted retires (wraps)
//   cycle_count         enabled, non-stopped cycles (wraps)
//   halted, timeout     sticky stop flags
//   overflow            sticky, set when a record was dropped
//   drop_count          dropped records, saturating at 255
//   done                stopped and FIFO drained
// ----------------------------------------------------------------------------
module trace_capture #(
    parameter int DW        = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int CYC_LIMIT = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ret_valid,
    input  logic [DW-1:0]    pc,
    input  logic             reg_we,
    input  logic [3:0]       reg_idx,
    input  logic [DW-1:0]    reg_data,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [DW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_data,
    input  logic             hlt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic             out_ld,
    output logic [CNT_W-1:0] out_inum,
    output logic [DW-1:0]    out_pc,
    output logic [3:0]       out_reg,
    output logic [DW-1:0]    out_addr,
    output logic [DW-1:0]    out_value,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output logic             timeout,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CYC_LIMIT_C = CNT_W'(CYC_LIMIT);

    typedef enum logic [1:0] {
        KIND_OTHER = 2'b00,
        KIND_REG   = 2'b01,
        KIND_STORE = 2'b10,
        KIND_HALT  = 2'b11
    } kind_t;

    // ------------------------------------------------------------------
    // Record storage (no reset needed: head fields are gated by empty)
    // ------------------------------------------------------------------
    kind_t            memKind  [DEPTH];
    logic             memLd    [DEPTH];
    logic [CNT_W-1:0] memInum  [DEPTH];
    logic [DW-1:0]    memPc    [DEPTH];
    logic [3:0]       memReg   [DEPTH];
    logic [DW-1:0]    memAddr  [DEPTH];
    logic [DW-1:0]    memValue [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;
    logic [AW-1:0] wrIdx;
    logic [AW-1:0] rdIdx;

    logic empty;
    logic full;
    logic accept;
    logic pop;
    logic push;
    logic drop;
    logic cycEn;

    logic [CNT_W-1:0] cycleNext;

    // Classified record for the retire presented this cycle
    kind_t         recKind;
    logic          recLd;
    logic [3:0]    recReg;
    logic [DW-1:0] recAddr;
    logic [DW-1:0] recValue;

    assign wrIdx = wrPtr[AW-1:0];
    assign rdIdx = rdPtr[AW-1:0];

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrIdx == rdIdx);

    assign accept = en & ret_valid & ~halted & ~timeout;
    assign pop    = ~empty & out_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    assign cycEn     = en & ~halted & ~timeout;
    assign cycleNext = cycle_count + 1'b1;

    // ------------------------------------------------------------------
    // Retire classification: reg write wins over halt, halt over store
    // ------------------------------------------------------------------
    always_comb begin
        recKind  = KIND_OTHER;
        recLd    = 1'b0;
        recReg   = '0;
        recAddr  = '0;
        recValue = '0;
        if (reg_we) begin
            recKind  = KIND_REG;
            recLd    = mem_rd;
            recReg   = reg_idx;
            recValue = reg_data;
            if (mem_rd) begin
                recAddr = mem_addr;
            end
        end else if (hlt) begin
            recKind = KIND_HALT;
        end else if (mem_wr) begin
            recKind  = KIND_STORE;
            recAddr  = mem_addr;
            recValue = mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Record write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            memKind[wrIdx]  <= recKind;
            memLd[wrIdx]    <= recLd;
            memInum[wrIdx]  <= inst_count;
            memPc[wrIdx]    <= pc;
            memReg[wrIdx]   <= recReg;
            memAddr[wrIdx]  <= recAddr;
            memValue[wrIdx] <= recValue;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end

            // The instruction number advances even when the record is dropped.
            if (accept) begin
                inst_count <= inst_count + 1'b1;
                if (recKind == KIND_HALT) begin
                    halted <= 1'b1;
                end
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end

            if (cycEn) begin
                cycle_count <= cycleNext;
                if (cycleNext == CYC_LIMIT_C) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Head outputs (zero while empty, which also covers reset)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = ~empty;
        out_kind  = '0;
        out_ld    = 1'b0;
        out_inum  = '0;
        out_pc    = '0;
        out_reg   = '0;
        out_addr  = '0;
        out_value = '0;
        if (!empty) begin
            out_kind  = memKind[rdIdx];
            out_ld    = memLd[rdIdx];
            out_inum  = memInum[rdIdx];
            out_pc    = memPc[rdIdx];
            out_reg   = memReg[rdIdx];
            out_addr  = memAddr[rdIdx];
            out_value = memValue[rdIdx];
        end
    end

    assign done = (halted | timeout) & empty;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

    localparam int DW    = 16;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             ret_valid;
    logic [DW-1:0]    pc;
    logic             reg_we;
    logic [3:0]       reg_idx;
    logic [DW-1:0]    reg_data;
    logic             mem_rd;
    logic             mem_wr;
    logic [DW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data;
    logic             hlt;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_kind;
    logic             out_ld;
    logic [CNT_W-1:0] out_inum;
    logic [DW-1:0]    out_pc;
    logic [3:0]       out_reg;
    logic [DW-1:0]    out_addr;
    logic [DW-1:0]    out_value;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] cycle_count;
    logic             halted;
    logic             timeout;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             done;

    int total;
    int bad;

    trace_capture #(
        .DW(DW),
        .DEPTH(4),
        .CNT_W(CNT_W),
        .CYC_LIMIT(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .ret_valid(ret_valid),
        .pc(pc),
        .reg_we(reg_we),
        .reg_idx(reg_idx),
        .reg_data(reg_data),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .hlt(hlt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_kind(out_kind),
        .out_ld(out_ld),
        .out_inum(out_inum),
        .out_pc(out_pc),
        .out_reg(out_reg),
        .out_addr(out_addr),
        .out_value(out_value),
        .inst_count(inst_count),
        .cycle_count(cycle_count),
        .halted(halted),
        .timeout(timeout),
        .overflow(overflow),
        .drop_count(drop_count),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en        = 1'b0;
        ret_valid = 1'b0;
        pc        = '0;
        reg_we    = 1'b0;
        reg_idx   = '0;
        reg_data  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        hlt       = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic doReset();
        idle();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        // Asynchronous reset state, before any clock edge
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_inst", 64'(inst_count), 64'd0);
        check("rst_cycle", 64'(cycle_count), 64'd0);
        check("rst_flags", 64'({halted, timeout, overflow, done}), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_head", 64'({out_kind, out_pc, out_value}), 64'd0);
        #4;
        rst_n = 1'b1;
        step();

        // ---- Register write record ----
        en = 1'b1; ret_valid = 1'b1; reg_we = 1'b1; reg_idx = 4'd3;
        reg_data = 16'h0012; pc = 16'h0004;
        check("rw_no_bypass", 64'(out_valid), 64'd0);
        step();
        en = 1'b0; ret_valid = 1'b0;
        check("rw_valid", 64'(out_valid), 64'd1);
        check("rw_kind", 64'(out_kind), 64'd1);
        check("rw_ld", 64'(out_ld), 64'd0);
        check("rw_inum", 64'(out_inum), 64'd0);
        check("rw_reg", 64'(out_reg), 64'd3);
        check("rw_value", 64'(out_value), 64'h0012);
        check("rw_pc", 64'(out_pc), 64'h0004);
        check("rw_addr", 64'(out_addr), 64'd0);
        check("rw_inst", 64'(inst_count), 64'd1);
        check("rw_cycle", 64'(cycle_count), 64'd1);
        step();
        check("rw_hold_inum", 64'(out_inum), 64'd0);
        check("rw_hold_value", 64'(out_value), 64'h0012);
        out_ready = 1'b1;
        step();
        check("rw_popped", 64'(out_valid), 64'd0);
        check("rw_empty_value", 64'(out_value), 64'd0);

        // ---- Load then store ----
        doReset();
        en = 1'b1; ret_valid = 1'b1; reg_we = 1'b1; mem_rd = 1'b1;
        reg_idx = 4'd5; mem_addr = 16'h0040; reg_data = 16'hBEEF;
        mem_data = 16'h5555; pc = 16'h0010;
        step();
        reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b1;
        mem_addr = 16'h0042; mem_data = 16'h1234; pc = 16'h0014;
        step();
        idle();
        check("ld_kind", 64'(out_kind), 64'd1);
        check("ld_ld", 64'(out_ld), 64'd1);
        check("ld_addr", 64'(out_addr), 64'h0040);
        check("ld_value", 64'(out_value), 64'hBEEF);
        check("ld_inum", 64'(out_inum), 64'd0);
        check("ld_reg", 64'(out_reg), 64'd5);
        out_ready = 1'b1;
        step();
        check("st_kind", 64'(out_kind), 64'd2);
        check("st_ld", 64'(out_ld), 64'd0);
        check("st_addr", 64'(out_addr), 64'h0042);
        check("st_value", 64'(out_value), 64'h1234);
        check("st_inum", 64'(out_inum), 64'd1);
        check("st_reg", 64'(out_reg), 64'd0);
        check("st_pc", 64'(out_pc), 64'h0014);
        step();
        check("st_drained", 64'(out_valid), 64'd0);

        // ---- Overflow with DEPTH=4, then full+pop ----
        doReset();
        en = 1'b1; ret_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc = 16'(16'h0100 + 4 * i);
            step();
        end
        en = 1'b0;
        check("ov_flag", 64'(overflow), 64'd1);
        check("ov_drops", 64'(drop_count), 64'd2);
        check("ov_inst", 64'(inst_count), 64'd6);
        check("ov_cycle", 64'(cycle_count), 64'd6);
        check("ov_head_inum", 64'(out_inum), 64'd0);
        check("ov_head_pc", 64'(out_pc), 64'h0100);
        step();
        check("en_low_inst", 64'(inst_count), 64'd6);
        check("en_low_drops", 64'(drop_count), 64'd2);
        en = 1'b1; out_ready = 1'b1; pc = 16'h0200;
        step();
        en = 1'b0; ret_valid = 1'b0;
        check("fp_drops", 64'(drop_count), 64'd2);
        check("fp_inst", 64'(inst_count), 64'd7);
        check("fp_cycle", 64'(cycle_count), 64'd7);
        check("fp_head1", 64'(out_inum), 64'd1);
        step();
        check("fp_head2", 64'(out_inum), 64'd2);
        step();
        check("fp_head3", 64'(out_inum), 64'd3);
        step();
        check("fp_head6", 64'(out_inum), 64'd6);
        check("fp_head6_pc", 64'(out_pc), 64'h0200);
        step();
        check("fp_drained", 64'(out_valid), 64'd0);
        check("fp_ovf_sticky", 64'(overflow), 64'd1);

        // ---- Halt at instruction 5 ----
        doReset();
        en = 1'b1; ret_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 16'(16'h0300 + 4 * i);
            step();
        end
        hlt = 1'b1; pc = 16'h0314;
        step();
        check("ht_kind", 64'(out_kind), 64'd3);
        check("ht_inum", 64'(out_inum), 64'd5);
        check("ht_pc", 64'(out_pc), 64'h0314);
        check("ht_halted", 64'(halted), 64'd1);
        check("ht_not_done", 64'(done), 64'd0);
        hlt = 1'b0; reg_we = 1'b1; reg_idx = 4'd7;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("ht_inst", 64'(inst_count), 64'd6);
        check("ht_cycle", 64'(cycle_count), 64'd6);
        check("ht_empty", 64'(out_valid), 64'd0);
        check("ht_done", 64'(done), 64'd1);

        // ---- Watchdog, then asynchronous reset mid-run ----
        doReset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
        end
        check("wd_cycle9", 64'(cycle_count), 64'd9);
        check("wd_no_to", 64'(timeout), 64'd0);
        ret_valid = 1'b1; pc = 16'h0400;
        step();
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_cycle10", 64'(cycle_count), 64'd10);
        check("wd_last_accepted", 64'(inst_count), 64'd1);
        check("wd_rec_inum", 64'(out_inum), 64'd0);
        check("wd_rec_pc", 64'(out_pc), 64'h0400);
        check("wd_not_done", 64'(done), 64'd0);
        step();
        step();
        check("wd_ignored", 64'(inst_count), 64'd1);
        check("wd_frozen", 64'(cycle_count), 64'd10);
        check("wd_no_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b0;
        #2;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_inst", 64'(inst_count), 64'd0);
        check("ar_cycle", 64'(cycle_count), 64'd0);
        check("ar_flags", 64'({halted, timeout, overflow, done}), 64'd0);
        check("ar_head", 64'({out_pc, out_inum}), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_no_stale", 64'(out_valid), 64'd0);
        check("ar_done", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameters SHALL be: DW, default 16, datapath/PC width; DEPTH, default 16, record FIFO entries (power of 2, >=2); CNT_W, default 32, counter width; CYC_LIMIT, default 100000, watchdog cycle limit.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable (core out of reset)
- ret_valid  in  1  one instruction retires this cycle
- pc  in  DW  PC of retiring instruction
- reg_we  in  1  register file write
- reg_idx  in  4  destination register
- reg_data  in  DW  register write data
- mem_rd  in  1  load (data memory read to register)
- mem_wr  in  1  data memory write
- mem_addr  in  DW  data memory address
- mem_data  in  DW  store data
- hlt  in  1  halt retiring
- out_valid  out  1  record available at FIFO head
- out_ready  in  1  consumer accepts head record
- out_kind  out  2  00 other/branch/NOP, 01 reg write, 10 store, 11 halt
- out_ld  out  1  reg-write record is a load
- out_inum  out  CNT_W  instruction number of record
- out_pc  out  DW  record PC
- out_reg  out  4  record register index (0 if unused)
- out_addr  out  DW  record memory address (0 if unused)
- out_value  out  DW  reg_data for kind 01, mem_data for kind 10, else 0
- inst_count  out  CNT_W  retires seen
- cycle_count  out  CNT_W  enabled cycles seen
- halted, timeout, overflow  out  1 each  sticky status flags
- drop_count  out  8  records dropped, saturating at 255
- done  out  1  (halted|timeout) & FIFO empty

Function
REQ-003 Accepted retire SHALL be en & ret_valid & ~halted & ~timeout, sampled on the rising clk edge.
REQ-004 Classification precedence SHALL be: reg_we -> kind 01 (out_ld=mem_rd, out_addr=mem_addr only if mem_rd); else hlt -> 11; else mem_wr -> 10; else 00.
REQ-005 Each accepted retire SHALL carry out_inum = inst_count before increment, then inst_count += 1, whether or not the record is dropped; gaps in out_inum SHALL therefore mark drops.
REQ-006 The FIFO SHALL be first-word-fall-through; a pushed record SHALL appear at the head one cycle after push (no same-cycle bypass).
REQ-007 A pop SHALL occur when out_valid & out_ready; head fields SHALL hold stable while out_valid & ~out_ready.
REQ-008 Push into full FIFO with simultaneous pop SHALL be accepted; without a pop it SHALL be dropped, overflow set, drop_count incremented (saturating at 255).
REQ-009 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy count of log2(DEPTH)+1 bits.
REQ-010 A kind-11 record SHALL set halted on that edge; all later retires SHALL be ignored; halted SHALL set even if the halt record is dropped.
REQ-011 cycle_count SHALL increment each edge with en & ~halted & ~timeout; when it reaches CYC_LIMIT, timeout SHALL set on that edge and counting SHALL stop.
REQ-012 A retire on the edge timeout sets SHALL still be accepted; retires on later edges SHALL be ignored.
REQ-013 en low SHALL freeze both counters and block capture; draining SHALL continue.
REQ-014 Counters SHALL wrap modulo 2^CNT_W; status flags SHALL clear only on reset.

Reset
REQ-015 rst_n low SHALL immediately, asynchronously clear: FIFO pointers (out_valid=0), both counters, halted, timeout, overflow, drop_count, done.
REQ-016 Head output fields SHALL read 0 while FIFO empty and during reset.
REQ-017 Reset mid-operation SHALL discard all buffered records; no partial record SHALL remain after release.

Verification
REQ-018 Reg write: en=1, ret_valid, reg_we, reg_idx=3, reg_data=0x0012, pc=0x0004 -> next cycle out_valid=1, kind=01, ld=0, inum=0, reg=3, value=0x0012.
REQ-019 Load then store: ret reg_we+mem_rd addr 0x0040 data 0xBEEF; then mem_wr addr 0x0042 data 0x1234 -> records (01, ld=1, addr 0x0040, value 0xBEEF) then (10, addr 0x0042, value 0x1234), inum 0 and 1.
REQ-020 Overflow: DEPTH=4, out_ready=0, 6 consecutive retires -> 4 records held, overflow=1, drop_count=2, inst_count=6; drain shows inum 0..3.
REQ-021 Full+pop: full FIFO, out_ready=1 with retire same cycle -> no drop, occupancy stays DEPTH.
REQ-022 Halt: retire hlt=1 at inst 5, then 3 more retires -> halted=1, inst_count=6, last record kind 11 inum 5; done=1 after drain.
REQ-023 Watchdog/reset: CYC_LIMIT=10, en=1 with no halt -> timeout=1 at cycle_count=10, later retires ignored; rst_n low mid-run -> all outputs 0 immediately.
